// File: rtl/conv_pkg.sv
// Shared state encoding and sizing helpers for the convolution layer path.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    function automatic int out_side(input int n, input int k);
        return n - k + 1;
    endfunction

    // Never collapse to zero bits so single-entry ranges still get a port.
    function automatic int safe_clog2(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    function automatic int addr_width(input int n, input int k, input int oc);
        return safe_clog2(oc * out_side(n, k) * out_side(n, k));
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Nested in_ch/col/row walker with a running output write address.
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int OUT       = 6,
    parameter int NUM_IN_CH = 2,
    parameter int RW        = 4,
    parameter int CW        = 1,
    parameter int AW        = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [RW-1:0] col,
    output logic [CW-1:0] in_ch,
    output logic [AW-1:0] addr,
    output logic          first,
    output logic          in_last,
    output logic          last
);

    localparam logic [CW-1:0] IN_MAX  = CW'(NUM_IN_CH - 1);
    localparam logic [RW-1:0] POS_MAX = RW'(OUT - 1);

    logic col_wrap;
    logic row_wrap;

    always_comb begin
        first    = (in_ch == '0);
        in_last  = (in_ch == IN_MAX);
        col_wrap = (col == POS_MAX);
        row_wrap = (row == POS_MAX);
        last     = in_last && col_wrap && row_wrap;
    end

    // Address steps once per pixel; it stays contiguous across channels.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row   <= '0;
            col   <= '0;
            in_ch <= '0;
            addr  <= '0;
        end else if (advance) begin
            if (in_last) begin
                in_ch <= '0;
                addr  <= addr + AW'(1);
                if (col_wrap) begin
                    col <= '0;
                    row <= row_wrap ? '0 : row + RW'(1);
                end else begin
                    col <= col + RW'(1);
                end
            end else begin
                in_ch <= in_ch + CW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer: loads each filter set, then streams window descriptors.
module conv_layer_ctrl
    import conv_pkg::*;
#(
    parameter int N          = 10,
    parameter int K          = 5,
    parameter int NUM_IN_CH  = 2,
    parameter int NUM_OUT_CH = 2,
    localparam int OUT = out_side(N, K),
    localparam int RW  = safe_clog2(N),
    localparam int CW  = safe_clog2(NUM_IN_CH),
    localparam int OW  = safe_clog2(NUM_OUT_CH),
    localparam int AW  = addr_width(N, K, NUM_OUT_CH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          flt_req,
    output logic [OW-1:0] flt_ch,
    input  logic          flt_ack,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [RW-1:0] win_row,
    output logic [RW-1:0] win_col,
    output logic [CW-1:0] win_in_ch,
    output logic          acc_first,
    output logic          acc_last,
    output logic [AW-1:0] wr_addr
);

    localparam logic [OW-1:0] OC_MAX = OW'(NUM_OUT_CH - 1);

    state_t        state;
    state_t        state_nx;
    logic [OW-1:0] out_ch;
    logic          accept;
    logic          more_ch;
    logic          clear;
    logic          pos_last;
    logic          first;
    logic          in_last;
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic [CW-1:0] in_ch;
    logic [AW-1:0] addr;

    assign accept  = (state == RUN) && win_ready;
    assign more_ch = (out_ch != OC_MAX);
    assign clear   = (state == IDLE) || (state == DONE);

    conv_pos_counter #(
        .OUT       (OUT),
        .NUM_IN_CH (NUM_IN_CH),
        .RW        (RW),
        .CW        (CW),
        .AW        (AW)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .advance (accept),
        .row     (row),
        .col     (col),
        .in_ch   (in_ch),
        .addr    (addr),
        .first   (first),
        .in_last (in_last),
        .last    (pos_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            out_ch <= '0;
        end else if (accept && pos_last && more_ch) begin
            out_ch <= out_ch + OW'(1);
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        done      = 1'b0;
        flt_req   = 1'b0;
        win_valid = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                flt_req = 1'b1;
                if (flt_ack) state_nx = RUN;
            end
            RUN: begin
                win_valid = 1'b1;
                if (accept && pos_last) begin
                    state_nx = more_ch ? LOAD : DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign flt_ch    = out_ch;
    assign win_row   = row;
    assign win_col   = col;
    assign win_in_ch = in_ch;
    assign wr_addr   = addr;
    assign acc_first = (state == RUN) && first;
    assign acc_last  = (state == RUN) && in_last;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Directed bench for conv_layer_ctrl: default layer plus a 1x1x1 variant.
module tb_conv_layer_ctrl;

    localparam int TOTAL = 144;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       flt_ack = 1'b0;
    logic       win_ready = 1'b0;
    logic       busy, done, flt_req, win_valid, acc_first, acc_last;
    logic [0:0] flt_ch, win_in_ch;
    logic [3:0] win_row, win_col;
    logic [6:0] wr_addr;

    logic       d_start = 1'b0;
    logic       d_flt_ack = 1'b0;
    logic       d_win_ready = 1'b0;
    logic       d_busy, d_done, d_flt_req, d_win_valid;
    logic       d_acc_first, d_acc_last;
    logic [0:0] d_flt_ch, d_win_in_ch, d_wr_addr;
    logic [2:0] d_win_row, d_win_col;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    conv_layer_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .done(done), .flt_req(flt_req), .flt_ch(flt_ch),
        .flt_ack(flt_ack), .win_valid(win_valid),
        .win_ready(win_ready), .win_row(win_row),
        .win_col(win_col), .win_in_ch(win_in_ch),
        .acc_first(acc_first), .acc_last(acc_last),
        .wr_addr(wr_addr)
    );

    conv_layer_ctrl #(
        .N(5), .K(5), .NUM_IN_CH(1), .NUM_OUT_CH(1)
    ) dut_min (
        .clk(clk), .reset(reset), .start(d_start), .busy(d_busy),
        .done(d_done), .flt_req(d_flt_req), .flt_ch(d_flt_ch),
        .flt_ack(d_flt_ack), .win_valid(d_win_valid),
        .win_ready(d_win_ready), .win_row(d_win_row),
        .win_col(d_win_col), .win_in_ch(d_win_in_ch),
        .acc_first(d_acc_first), .acc_last(d_acc_last),
        .wr_addr(d_wr_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cur_desc();
        return {14'd0, win_row, win_col, win_in_ch,
                acc_first, acc_last, wr_addr};
    endfunction

    // Expected descriptor for the idx-th accepted window of a layer.
    function automatic logic [31:0] exp_desc(input int idx);
        int ic = idx % 2;
        int pos = (idx / 2) % 36;
        int oc = idx / 72;
        logic [3:0] r = 4'(pos / 6);
        logic [3:0] c = 4'(pos % 6);
        return {14'd0, r, c, 1'(ic), ic == 0, ic == 1,
                7'(oc * 36 + pos)};
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_flt_req"}, 32'(flt_req), 0);
        chk({tag, "_valid"}, 32'(win_valid), 0);
        chk({tag, "_desc"}, cur_desc(), 0);
    endtask

    task automatic run_layer(input int ack_delay, input bit stall,
                             input int abort_at, input bit poke);
        int idx = 0;
        int cyc = 0;
        int req_cnt = 0;
        int req_wait = 0;
        int key;
        bit held = 0;
        bit fin = 0;
        logic [31:0] saved = '0;
        bit seen [TOTAL];
        foreach (seen[i]) seen[i] = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("flt_req_after_start", 32'(flt_req), 1);
        while (!fin) begin
            if (held) begin
                chk("valid_held", 32'(win_valid), 1);
                chk("desc_stable", cur_desc(), saved);
            end
            held = 0;
            flt_ack = 1'b0;
            win_ready = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            start = poke && (cyc % 3 == 1);
            if (flt_req) begin
                if (req_wait == 0) begin
                    req_cnt++;
                    chk("flt_ch", 32'(flt_ch), 32'(req_cnt - 1));
                end
                chk("no_valid_in_load", 32'(win_valid), 0);
                if (req_wait == ack_delay) begin
                    flt_ack = 1'b1;
                    req_wait = 0;
                end else begin
                    req_wait++;
                end
            end else if (poke) begin
                flt_ack = 1'b1;
            end
            if (win_valid) begin
                if (!stall) win_ready = 1'b1;
                if (idx == abort_at) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    start = 1'b0;
                    flt_ack = 1'b0;
                    win_ready = 1'b0;
                    check_zero("abort");
                    return;
                end
                if (win_ready) begin
                    chk("desc", cur_desc(), exp_desc(idx));
                    key = int'(flt_ch) * 72
                        + (int'(win_row) * 6 + int'(win_col)) * 2
                        + int'(win_in_ch);
                    if (key < TOTAL) begin
                        chk("tuple_once", 32'(seen[key]), 0);
                        seen[key] = 1'b1;
                    end
                    idx++;
                end else begin
                    held = 1;
                    saved = cur_desc();
                end
            end
            if (done) begin
                chk("win_count", 32'(idx), TOTAL);
                chk("req_count", 32'(req_cnt), 2);
                start = poke;
                flt_ack = 1'b0;
                win_ready = 1'b0;
                @(negedge clk);
                start = 1'b0;
                chk("busy_after_done", 32'(busy), 0);
                chk("done_one_cycle", 32'(done), 0);
                fin = 1;
            end else begin
                @(negedge clk);
                cyc++;
                if (cyc > 3000) begin
                    chk("timeout_windows", 32'(idx), TOTAL);
                    chk("timeout_done", 32'(done), 1);
                    fin = 1;
                end
            end
        end
        start = 1'b0;
        flt_ack = 1'b0;
        win_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("reset_d_busy", 32'(d_busy), 0);
        chk("reset_d_valid", 32'(d_win_valid), 0);
        reset = 1'b0;

        run_layer(1, 1'b0, -1, 1'b0);
        run_layer(1, 1'b1, -1, 1'b0);
        run_layer(7, 1'b0, -1, 1'b0);
        run_layer(1, 1'b0, 50, 1'b0);
        run_layer(1, 1'b0, -1, 1'b0);
        run_layer(1, 1'b1, -1, 1'b1);
        run_layer(1, 1'b0, -1, 1'b0);

        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        chk("d_flt_req", 32'(d_flt_req), 1);
        chk("d_flt_ch", 32'(d_flt_ch), 0);
        d_flt_ack = 1'b1;
        @(negedge clk);
        d_flt_ack = 1'b0;
        chk("d_valid", 32'(d_win_valid), 1);
        chk("d_row", 32'(d_win_row), 0);
        chk("d_col", 32'(d_win_col), 0);
        chk("d_first", 32'(d_acc_first), 1);
        chk("d_last", 32'(d_acc_last), 1);
        chk("d_addr", 32'(d_wr_addr), 0);
        d_win_ready = 1'b1;
        @(negedge clk);
        d_win_ready = 1'b0;
        chk("d_done", 32'(d_done), 1);
        chk("d_valid_off", 32'(d_win_valid), 0);
        @(negedge clk);
        chk("d_busy_off", 32'(d_busy), 0);
        chk("d_done_off", 32'(d_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
